// File: rtl/mem_pipe_buf.sv
// Single-clock 1W1R memory with a 1..3 stage registered read pipeline,
// per-read valid/error tracking and selectable read-during-write behaviour.
module mem_pipe_buf #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err
);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("mem_pipe_buf: RD_LAT must be in 1..3");
  end

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;
  logic             hit;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] dat_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;

  // Out-of-range addresses are never aliased onto real words.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok = {1'b0, rd_addr} < DEPTH_W;
  assign hit   = (WR_FIRST != 0) && wr_ok && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = hit ? wr_data : mem[rd_addr];
  end

  // Output strobe: rd_valid is a one-cycle pulse with no ready; the consumer
  // must take rd_data/rd_err in every cycle rd_valid is high. Data registers
  // only advance behind a valid entry, so rd_data holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      err_q[0] <= rd_en && !rd_ok;
      if (rd_en) dat_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_data  = dat_q[RD_LAT-1];
  assign rd_valid = vld_q[RD_LAT-1];
  assign rd_err   = err_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_pipe_buf.sv
// Bench for mem_pipe_buf: three instances share one stimulus stream
// (lat1/write-first/16, lat2/read-first/16, lat3/write-first/12).
module tb_mem_pipe_buf;

  localparam int QW = 25; // {due[15:0], err, data[7:0]}

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rdat [3];
  logic       rvld [3];
  logic       rerr [3];

  logic [QW-1:0] exp_q0[$];
  logic [QW-1:0] exp_q1[$];
  logic [QW-1:0] exp_q2[$];
  logic [7:0]    m16 [16];
  logic [7:0]    m12 [12];
  logic [7:0]    last_d [3];
  int            cyc;
  int            checks;
  int            errors;

  mem_pipe_buf #(.WIDTH(8), .DEPTH(16), .RD_LAT(1), .WR_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[0]), .rd_valid(rvld[0]), .rd_err(rerr[0]));
  mem_pipe_buf #(.WIDTH(8), .DEPTH(16), .RD_LAT(2), .WR_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[1]), .rd_valid(rvld[1]), .rd_err(rerr[1]));
  mem_pipe_buf #(.WIDTH(8), .DEPTH(12), .RD_LAT(3), .WR_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[2]), .rd_valid(rvld[2]), .rd_err(rerr[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return k + 1;
  endfunction

  function automatic int dep_of(int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic bit wrf_of(int k);
    return k != 1;
  endfunction

  task automatic set_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic flush_sb();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    for (int k = 0; k < 3; k++) last_d[k] = 8'h00;
  endtask

  // One clock: push expectations for the read sampled at the coming edge,
  // update the reference memory, then pop/compare at posedge+1.
  task automatic tick();
    logic [7:0]    ed;
    logic          ee;
    logic [QW-1:0] ent;
    logic          have;
    if (rst_n && rd_en) begin
      for (int k = 0; k < 3; k++) begin
        ee = 1'b0;
        ed = 8'h00;
        if (int'(rd_addr) >= dep_of(k)) ee = 1'b1;
        else begin
          ed = (k == 2) ? m12[rd_addr] : m16[rd_addr];
          if (wrf_of(k) && wr_en && wr_addr == rd_addr) ed = wr_data;
        end
        ent = {16'(cyc + lat_of(k)), ee, ed};
        case (k)
          0:       exp_q0.push_back(ent);
          1:       exp_q1.push_back(ent);
          default: exp_q2.push_back(ent);
        endcase
      end
    end
    if (rst_n && wr_en) begin
      m16[wr_addr] = wr_data;
      if (wr_addr < 4'd12) m12[wr_addr] = wr_data;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      ent = '0;
      have = 1'b0;
      case (k)
        0:       if (exp_q0.size() > 0) begin ent = exp_q0[0]; have = 1'b1; end
        1:       if (exp_q1.size() > 0) begin ent = exp_q1[0]; have = 1'b1; end
        default: if (exp_q2.size() > 0) begin ent = exp_q2[0]; have = 1'b1; end
      endcase
      checks++;
      if (!rst_n) begin
        if (rvld[k] !== 1'b0 || rerr[k] !== 1'b0 || rdat[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset_out dut%0d cyc %0d: got v=%b e=%b d=%h want 0/0/00",
                   k, cyc, rvld[k], rerr[k], rdat[k]);
        end
      end else if (have && ent[24:9] == 16'(cyc)) begin
        case (k)
          0:       void'(exp_q0.pop_front());
          1:       void'(exp_q1.pop_front());
          default: void'(exp_q2.pop_front());
        endcase
        if (rvld[k] !== 1'b1 || rerr[k] !== ent[8] || rdat[k] !== ent[7:0]) begin
          errors++;
          $display("FAIL read_result dut%0d cyc %0d: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                   k, cyc, rvld[k], rerr[k], rdat[k], ent[8], ent[7:0]);
        end
        last_d[k] = ent[7:0];
      end else begin
        if (rvld[k] !== 1'b0 || rdat[k] !== last_d[k]) begin
          errors++;
          $display("FAIL idle_hold dut%0d cyc %0d: got v=%b d=%h want v=0 d=%h",
                   k, cyc, rvld[k], rdat[k], last_d[k]);
        end
      end
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    set_idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
  endtask

  task automatic do_read(input logic [3:0] a);
    set_idle();
    rd_en = 1'b1; rd_addr = a;
    tick();
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b0;
      rd_en = 1'($urandom_range(0, 1));
      rd_addr = 4'($urandom_range(0, 15));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    set_idle();
    rst_n = 1'b1;
    idle(5);
    checks++;
    if (rvld[0] !== 1'b0 || rvld[1] !== 1'b0 || rvld[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b%b%b want 000", rvld[0], rvld[1], rvld[2]);
    end
  endtask

  task automatic test_latency();
    do_write(4'd3, 8'hA5);
    idle(1);
    do_read(4'd3);
    idle(4);
    checks++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      errors++;
      $display("FAIL latency_drain: got %0d pending want 0",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i * 17));
    for (int i = 0; i < 16; i++) do_read(4'(i));
    idle(4);
    checks++;
    if (last_d[0] !== 8'hFF || last_d[1] !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_last: got %h %h want ff ff", last_d[0], last_d[1]);
    end
  endtask

  task automatic test_collision();
    do_write(4'd5, 8'h3C);
    set_idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hC3;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    do_read(4'd5);
    idle(4);
    checks++;
    if (m16[5] !== 8'hC3 || last_d[1] !== 8'hC3) begin
      errors++;
      $display("FAIL collision_follow: got %h want c3", last_d[1]);
    end
  endtask

  task automatic test_range();
    do_write(4'd13, 8'h77);
    do_read(4'd13);
    do_read(4'd11);
    idle(4);
    for (int i = 0; i < 16; i++) do_read(4'(i));
    idle(4);
    checks++;
    if (exp_q2.size() != 0) begin
      errors++;
      $display("FAIL range_drain: got %0d pending want 0", exp_q2.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom_range(0, 255));
      rd_en = 1'($urandom_range(0, 3) != 0);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      tick();
    end
    idle(4);
  endtask

  task automatic test_midflight_reset();
    do_read(4'd2);
    do_read(4'd7);
    set_idle();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rvld[2] !== 1'b0 || rvld[1] !== 1'b0 || rdat[2] !== 8'h00) begin
      errors++;
      $display("FAIL async_flush: got v=%b d=%h want v=0 d=00", rvld[2], rdat[2]);
    end
    flush_sb();
    idle(3);
    rst_n = 1'b1;
    idle(4);
    for (int i = 0; i < 16; i++) do_read(4'(i));
    idle(4);
    checks++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending want 0",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    set_idle();
    flush_sb();
    test_reset();
    test_latency();
    test_back_to_back();
    test_collision();
    test_range();
    test_random();
    test_midflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
